// File: rtl/cipher_out_fifo.sv
// -----------------------------------------------------------------------------
// cipher_out_fifo
//   Small ciphertext output queue between the encryption core and a consumer.
//   A registered memory with one cycle of latency: a word pushed at one edge
//   becomes visible on the output after that edge. There is no fall-through.
//   A zeroize request wipes every entry, one entry per cycle. After the wipe
//   the queue is empty and wipe_done pulses. A popped entry is cleared in the
//   same cycle, so ciphertext never stays in a freed slot.
//
// Parameters
//   N      ciphertext width in bits
//   DEPTH  entry count (power of two, >= 2)
//
// Ports
//   clk        single clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_data    ciphertext from the encryption core
//   in_valid   in_data is valid
//   in_ready   queue accepts in_data this cycle
//   zeroize    request to wipe all stored ciphertext
//   out_data   head-of-queue ciphertext; all-zero whenever out_valid=0
//   out_valid  out_data is valid
//   out_ready  consumer takes out_data
//   count      current occupancy, 0..DEPTH
//   wipe_done  one-cycle pulse on the last wipe cycle
// -----------------------------------------------------------------------------
module cipher_out_fifo #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N-1:0]               in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       zeroize,
    output logic [N-1:0]               out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       wipe_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WIPE = 1'b1;

    logic [0:0]    r_state;
    logic [N-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wipe_idx;

    logic          w_run;
    logic          w_wipe;
    logic          w_push;
    logic          w_pop;
    logic          w_wipe_last;
    logic [DEPTH-1:0] w_wr_sel;
    logic [DEPTH-1:0] w_clr_sel;

    assign w_run       = (r_state == ST_RUN);
    assign w_wipe      = (r_state == ST_WIPE);
    assign w_wipe_last = w_wipe && (r_wipe_idx == AW'(DEPTH - 1));

    // rst_n gates in_ready directly, so upstream sees "not ready" while
    // reset is held and no edge is needed for that.
    assign in_ready  = w_run && (r_count < CW'(DEPTH)) && !zeroize && rst_n;
    assign out_valid = w_run && (r_count != '0) && !zeroize;

    // Mask the head with out_valid so that stale ciphertext never appears on
    // the bus. This covers the wipe and the cycle in which zeroize is raised.
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign wipe_done = w_wipe_last;
    assign count     = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Decode each entry's write and clear enables. A push and a pop in the
    // same cycle cannot hit the same slot. A pop needs count>0 and a push
    // needs count<DEPTH, so the two pointers differ when both occur.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
        assign w_wr_sel[gi]  = w_push && (r_wr_ptr == AW'(gi));
        assign w_clr_sel[gi] = (w_pop  && (r_rd_ptr   == AW'(gi))) ||
                               (w_wipe && (r_wipe_idx == AW'(gi)));
    end

    // The storage is a register array, not block RAM. Reset must clear every
    // entry at once, and that needs registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_clr_sel[i]) begin
                    r_mem[i] <= '0;
                end else if (w_wr_sel[i]) begin
                    r_mem[i] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wipe_idx <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (zeroize) begin
                        // A zeroize request blocks any push or pop in this cycle.
                        r_state    <= ST_WIPE;
                        r_wipe_idx <= '0;
                    end else begin
                        if (w_push) begin
                            r_wr_ptr <= r_wr_ptr + AW'(1);
                        end
                        if (w_pop) begin
                            r_rd_ptr <= r_rd_ptr + AW'(1);
                        end
                        if (w_push && !w_pop) begin
                            r_count <= r_count + CW'(1);
                        end else if (w_pop && !w_push) begin
                            r_count <= r_count - CW'(1);
                        end
                    end
                end
                ST_WIPE: begin
                    // zeroize is ignored here. The wipe always takes DEPTH cycles.
                    r_wipe_idx <= r_wipe_idx + AW'(1);
                    if (w_wipe_last) begin
                        r_state    <= ST_RUN;
                        r_wr_ptr   <= '0;
                        r_rd_ptr   <= '0;
                        r_count    <= '0;
                        r_wipe_idx <= '0;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: doc/cipher_out_fifo.md
CIPHER_OUT_FIFO -- requirements
Module: cipher_out_fifo

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning ciphertext width in bits (matches the encryption core data_out width).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning entry count; power of two, >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_data, input, N bits: ciphertext from the encryption core's data_out.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the FIFO accepts in_data this cycle.
REQ-008 The block SHALL have port zeroize, input, 1 bit: request to wipe all stored ciphertext.
REQ-009 The block SHALL have port out_data, output, N bits: head-of-queue ciphertext.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes out_data.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-013 The block SHALL have port wipe_done, output, 1 bit: one-cycle pulse when a wipe completes.

Function
REQ-014 States SHALL be RUN and WIPE.
REQ-015 A push SHALL occur when in_valid && in_ready: write in_data at wr_ptr, wr_ptr+1.
REQ-016 A pop SHALL occur when out_valid && out_ready: rd_ptr+1, and the popped entry is cleared to 0 in the same cycle.
REQ-017 Pointers SHALL wrap modulo DEPTH; count = pushes minus pops, range 0..DEPTH.
REQ-018 in_ready SHALL equal (state==RUN) && (count<DEPTH) && !zeroize && rst_n.
REQ-019 out_valid SHALL equal (state==RUN) && (count!=0) && !zeroize.
REQ-020 out_data SHALL be mem[rd_ptr] when out_valid=1 and all-zero otherwise; stale ciphertext is never driven.
REQ-021 Latency SHALL be one cycle, with no fall-through: data pushed at edge k is visible with out_valid=1 after edge k.
REQ-022 Empty with in_valid=1: push only; out_valid stays 0 that cycle.
REQ-023 Full: in_ready=0 even if out_ready=1 (no same-cycle push-through); the pop frees the slot for the next cycle.
REQ-024 When 0<count<DEPTH, simultaneous push and pop SHALL both occur and count SHALL be unchanged.
REQ-025 zeroize=1 in RUN SHALL take priority over any push or pop that cycle; the next state is WIPE, with wipe index 0.
REQ-026 WIPE SHALL clear one entry per cycle (mem[idx]<=0, idx+1) for DEPTH cycles, with in_ready=0 and out_valid=0 throughout.
REQ-027 On the last WIPE cycle, the block SHALL set wr_ptr=rd_ptr=0 and count=0, pulse wipe_done=1 for one cycle, and return to RUN.
REQ-028 zeroize asserted during WIPE SHALL be ignored; the wipe neither restarts nor extends.
REQ-029 in_valid during WIPE SHALL be left pending; upstream holds in_data until in_ready=1.

Reset
REQ-030 While rst_n=0 the block SHALL immediately force state=RUN, all mem entries=0, pointers=0, count=0, wipe index=0, in_ready=0, out_valid=0, out_data=0, and wipe_done=0.
REQ-031 Reset assertion mid-WIPE or mid-transfer SHALL abort the operation; after release the FIFO is empty with in_ready=1.
REQ-032 The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-033 Basic: push 8'h66 then 8'h66, out_ready=0 -> count=2, out_data=8'h66; then out_ready=1 for 2 cycles -> two pops, count=0, out_data=8'h00.
REQ-034 Full: push 8'h01..8'h04 -> count=4, in_ready=0; hold in_valid with 8'h05 and out_ready=1 -> 8'h01 pops, 8'h05 is accepted the next cycle, and the order 02,03,04,05 is preserved across pointer wrap.
REQ-035 Simultaneous: count=2, push 8'hAA and pop in the same cycle -> count stays 2 and the head advances.
REQ-036 Zeroize: count=3, zeroize=1 with in_valid=1 and out_ready=1 -> no push or pop; 4 WIPE cycles with in_ready=0 and out_data=0; wipe_done pulses once; count=0; all mem=0 via hierarchical check.
REQ-037 Reset: rst_n=0 asynchronously mid-WIPE at count=2 -> all outputs 0 immediately; after release in_ready=1, count=0, and no old ciphertext ever appears on out_data.
